// File: rtl/uart_tx_arbiter_if.sv
// Requester/UART-side bundle for uart_tx_arbiter.
// master = arbiter, slave = requesters plus uart_tx_control.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int FRAME_SIZE = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*FRAME_SIZE-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic [FRAME_SIZE-1:0]         tx_data;
    logic                          tx_start;
    logic                          tx_busy;
    logic                          arb_busy;
    logic                          timeout_err;

    modport master (
        input  req, req_data, tx_busy,
        output gnt, tx_data, tx_start, arb_busy, timeout_err
    );

    modport slave (
        output req, req_data, tx_busy,
        input  gnt, tx_data, tx_start, arb_busy, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx_control among NUM_REQ requesters, round-robin by default.
// Define UART_TX_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int FRAME_SIZE    = 8,
    parameter int START_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    uart_tx_arbiter_if.master bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [PTR_W-1:0] win;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
    logic [PTR_W-1:0] rr_ptr;
`endif

    // Walk the search order backwards so the earliest candidate is written last.
    always_comb begin : pick
        int idx;
        idx = 0;
        win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
`endif
            if (bus.req[idx]) win = PTR_W'(idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            bus.gnt         <= '0;
            bus.tx_start    <= 1'b0;
            bus.tx_data     <= '0;
            bus.arb_busy    <= 1'b0;
            bus.timeout_err <= 1'b0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
            rr_ptr          <= '0;
`endif
        end else begin
            bus.gnt         <= '0;
            bus.tx_start    <= 1'b0;
            bus.timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state          <= WAIT_BUSY;
                        cnt            <= '0;
                        bus.gnt[win]   <= 1'b1;
                        bus.tx_start   <= 1'b1;
                        bus.tx_data    <= bus.req_data[win*FRAME_SIZE +: FRAME_SIZE];
                        bus.arb_busy   <= 1'b1;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
                        rr_ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
`endif
                    end
                end
                WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
                        state           <= IDLE;
                        bus.arb_busy    <= 1'b0;
                        bus.timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        state        <= IDLE;
                        bus.arb_busy <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.arb_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, corner sequences,
// and randomized traffic against a queue-free round-robin reference.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int FS = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N), .FRAME_SIZE(FS)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ(N),
        .FRAME_SIZE(FS),
        .START_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int mptr = 0;

    typedef struct {
        logic [N-1:0]    req;
        logic [N*FS-1:0] data;
        int              dly;
        int              len;
        logic [N-1:0]    exp_rr;
        logic [N-1:0]    exp_fp;
    } vec_t;

    vec_t tbl[11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int predict(input logic [N-1:0] r, input int p);
        int s;
        s = 0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
        s = p;
`endif
        for (int k = 0; k < N; k++)
            if (r[(s + k) % N]) return (s + k) % N;
        return -1;
    endfunction

    function automatic int idx_of(input logic [N-1:0] g);
        for (int i = 0; i < N; i++)
            if (g[i]) return i;
        return 0;
    endfunction

    task automatic do_txn(input logic [N-1:0] r, input logic [N*FS-1:0] d,
                          input int dly, input int len,
                          input logic [N-1:0] exp_g, input bit junk);
        int w;
        logic [FS-1:0] exp_d;
        w = idx_of(exp_g);
        exp_d = d[w*FS +: FS];
        bus.req = r;
        bus.req_data = d;
        step();
        chk("gnt", 32'(bus.gnt), 32'(exp_g));
        chk("tx_start", 32'(bus.tx_start), 32'd1);
        chk("tx_data", 32'(bus.tx_data), 32'(exp_d));
        chk("arb_busy_grant", 32'(bus.arb_busy), 32'd1);
        chk("timeout_grant", 32'(bus.timeout_err), 32'd0);
        mptr = (w + 1) % N;
        bus.req = junk ? N'($urandom) : '0;
        if (dly >= TO) begin
            for (int i = 1; i < TO; i++) begin
                step();
                chk("wb_gnt", 32'(bus.gnt), 32'd0);
                chk("wb_arb_busy", 32'(bus.arb_busy), 32'd1);
                chk("wb_timeout", 32'(bus.timeout_err), 32'd0);
                chk("wb_tx_data", 32'(bus.tx_data), 32'(exp_d));
                if (junk) bus.req = N'($urandom);
            end
            bus.req = '0;
            step();
            chk("timeout_pulse", 32'(bus.timeout_err), 32'd1);
            chk("timeout_arb_busy", 32'(bus.arb_busy), 32'd0);
            chk("timeout_gnt", 32'(bus.gnt), 32'd0);
            step();
            chk("timeout_clear", 32'(bus.timeout_err), 32'd0);
            chk("post_to_arb_busy", 32'(bus.arb_busy), 32'd0);
            chk("post_to_gnt", 32'(bus.gnt), 32'd0);
        end else begin
            for (int i = 0; i < dly; i++) begin
                step();
                chk("wb_gnt", 32'(bus.gnt), 32'd0);
                chk("wb_tx_start", 32'(bus.tx_start), 32'd0);
                chk("wb_arb_busy", 32'(bus.arb_busy), 32'd1);
                chk("wb_timeout", 32'(bus.timeout_err), 32'd0);
                chk("wb_tx_data", 32'(bus.tx_data), 32'(exp_d));
                if (junk) bus.req = N'($urandom);
            end
            bus.tx_busy = 1'b1;
            for (int i = 0; i < len; i++) begin
                step();
                chk("wd_arb_busy", 32'(bus.arb_busy), 32'd1);
                chk("wd_gnt", 32'(bus.gnt), 32'd0);
                chk("wd_tx_data", 32'(bus.tx_data), 32'(exp_d));
                if (junk) bus.req = N'($urandom);
            end
            bus.tx_busy = 1'b0;
            bus.req = '0;
            step();
            chk("done_arb_busy", 32'(bus.arb_busy), 32'd0);
            chk("done_gnt", 32'(bus.gnt), 32'd0);
            chk("done_tx_start", 32'(bus.tx_start), 32'd0);
        end
    endtask

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] e;
        logic [N*FS-1:0] d;
        int dly;
        int len;
        int w;

        tbl[0]  = '{4'b0001, 32'h11223341, 2, 10, 4'b0001, 4'b0001};
        tbl[1]  = '{4'b1111, 32'h8899AABB, 1, 3, 4'b0010, 4'b0001};
        tbl[2]  = '{4'b1111, 32'hDEADBEEF, 0, 1, 4'b0100, 4'b0001};
        tbl[3]  = '{4'b1111, 32'h0F1E2D3C, 3, 2, 4'b1000, 4'b0001};
        tbl[4]  = '{4'b1111, 32'h55667788, 1, 1, 4'b0001, 4'b0001};
        tbl[5]  = '{4'b0101, 32'hCAFEF00D, 2, 4, 4'b0100, 4'b0001};
        tbl[6]  = '{4'b1001, 32'h13579BDF, 1, 2, 4'b1000, 4'b0001};
        tbl[7]  = '{4'b1001, 32'h2468ACE0, 0, 3, 4'b0001, 4'b0001};
        tbl[8]  = '{4'b0010, 32'h600DF00D, 16, 0, 4'b0010, 4'b0010};
        tbl[9]  = '{4'b1011, 32'h7A6B5C4D, 1, 1, 4'b1000, 4'b0001};
        tbl[10] = '{4'b0011, 32'h9182A3B4, 15, 2, 4'b0001, 4'b0001};

        rst_n = 1'b1;
        bus.req = '0;
        bus.req_data = '0;
        bus.tx_busy = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_arb_busy", 32'(bus.arb_busy), 32'd0);
        chk("rst_timeout", 32'(bus.timeout_err), 32'd0);
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_gnt", 32'(bus.gnt), 32'd0);
            chk("idle_tx_start", 32'(bus.tx_start), 32'd0);
            chk("idle_arb_busy", 32'(bus.arb_busy), 32'd0);
        end

        for (int i = 0; i < 11; i++) begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
            e = tbl[i].exp_fp;
`else
            e = tbl[i].exp_rr;
`endif
            do_txn(tbl[i].req, tbl[i].data, tbl[i].dly, tbl[i].len, e, 1'b0);
        end

        // Request pulse that falls before any edge must be dropped.
        bus.req = 4'b0100;
        #2 bus.req = '0;
        step();
        chk("withdraw_gnt", 32'(bus.gnt), 32'd0);
        chk("withdraw_arb_busy", 32'(bus.arb_busy), 32'd0);

        // Reset while in WAIT_DONE with another requester pending.
        bus.req = 4'b0001;
        bus.req_data = 32'hA5C37E19;
        step();
        chk("pre_rst_gnt", 32'(bus.gnt), 32'd1);
        bus.req = '0;
        bus.tx_busy = 1'b1;
        step();
        bus.req = 4'b0010;
        step();
        chk("pre_rst_arb_busy", 32'(bus.arb_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(bus.gnt), 32'd0);
        chk("mid_rst_tx_start", 32'(bus.tx_start), 32'd0);
        chk("mid_rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("mid_rst_arb_busy", 32'(bus.arb_busy), 32'd0);
        chk("mid_rst_timeout", 32'(bus.timeout_err), 32'd0);
        #1 rst_n = 1'b1;
        mptr = 0;
        step();
        chk("post_rst_gnt", 32'(bus.gnt), 32'b0010);
        chk("post_rst_tx_start", 32'(bus.tx_start), 32'd1);
        chk("post_rst_tx_data", 32'(bus.tx_data), 32'h7E);
        mptr = 2;
        bus.req = '0;
        step();
        chk("post_rst_wd", 32'(bus.arb_busy), 32'd1);
        bus.tx_busy = 1'b0;
        step();
        chk("post_rst_idle", 32'(bus.arb_busy), 32'd0);

        for (int t = 0; t < 40; t++) begin
            r = N'($urandom_range(1, (1 << N) - 1));
            d = $urandom;
            dly = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 4));
            len = int'($urandom_range(1, 5));
            w = predict(r, mptr);
            e = '0;
            e[w] = 1'b1;
            do_txn(r, d, dly, len, e, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
